change_dispenser: RTL and testbench

Payout end of the vending machine coin path. The controller hands over a change amount in 10¢ units. This block pays it out one coin at a time by pulsing the coin-tube ejector solenoids, using the same one-hot denomination encoding as the coin inlet ($1, 50¢, 20¢, 10¢). It tracks per-tube inventory, confirms each ejection via the exit sensor, and reports done, shortfall and unpaid remainder back to the controller.

---
 rtl/change_dispenser.sv | 172 +++++++++++++++++
 tb/tb_change_dispenser.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin payout engine: greedily ejects coins from four tubes, confirms each via the
// exit sensor, tracks per-tube inventory and reports done/error/remaining.
module change_dispenser #(
    parameter int PULSE_CYCLES  = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int SENSE_TIMEOUT = 16,
    parameter int INV_W         = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [7:0]       change_amount,
    output logic             change_ready,
    input  logic             load_en,
    input  logic [3:0]       load_coin,
    input  logic [INV_W-1:0] load_count,
    input  logic             coin_sensed,
    output logic [3:0]       eject,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       remaining,
    output logic [3:0]       inv_empty
);
    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_PULSE, S_WAIT_SENSE, S_GAP, S_FINISH
    } state_e;

    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(SENSE_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             sensed_q, sensed_d;
    logic [7:0]       rem_q, rem_d;
    logic             err_q, err_d;
    logic [INV_W-1:0] inv_q [4];
    logic [INV_W-1:0] inv_d [4];
    logic             pick_found;
    logic [1:0]       pick_idx;
    logic             sense_now;
    logic             confirm;

    // Tube index to value in 10-cent units: 3=$1, 2=50c, 1=20c, 0=10c.
    function automatic logic [7:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd3:    return 8'd10;
            2'd2:    return 8'd5;
            2'd1:    return 8'd2;
            default: return 8'd1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            sensed_q <= 1'b0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            inv_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            sensed_q <= sensed_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            inv_q    <= inv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        sensed_d   = sensed_q;
        rem_d      = rem_q;
        err_d      = err_q;
        inv_d      = inv_q;
        confirm    = 1'b0;
        sense_now  = sensed_q | coin_sensed;
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        // Ascending scan: the last eligible tube is the largest usable coin.
        for (int i = 0; i < 4; i++) begin
            if (coin_value(2'(i)) <= rem_q && inv_q[i] != '0) begin
                pick_found = 1'b1;
                pick_idx   = 2'(i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (load_en && $onehot(load_coin)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (load_coin[i]) inv_d[i] = load_count;
                    end
                end
                if (change_valid) begin
                    rem_d   = change_amount;
                    err_d   = 1'b0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q == '0) begin
                    state_d = S_FINISH;
                end else if (pick_found) begin
                    sel_d    = pick_idx;
                    cnt_d    = '0;
                    sensed_d = 1'b0;
                    state_d  = S_PULSE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_PULSE: begin
                sensed_d = sense_now;
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    confirm = sense_now;
                    state_d = sense_now ? S_GAP : S_WAIT_SENSE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_SENSE: begin
                if (coin_sensed) begin
                    cnt_d   = '0;
                    confirm = 1'b1;
                    state_d = S_GAP;
                end else if (cnt_q == WAIT_LAST) begin
                    // Silent tube is assumed jammed or empty and taken out of service.
                    inv_d[sel_q] = '0;
                    state_d      = S_SELECT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (confirm) begin
            rem_d = rem_q - coin_value(sel_q);
            if (inv_q[sel_q] != '0) inv_d[sel_q] = inv_q[sel_q] - 1'b1;
        end
    end

    always_comb begin
        change_ready = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_FINISH);
        eject        = (state_q == S_PULSE) ? (4'b0001 << sel_q) : 4'b0000;
        error        = err_q;
        remaining    = rem_q;
        for (int i = 0; i < 4; i++) inv_empty[i] = (inv_q[i] == '0);
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized payouts compared
// against a transaction-level greedy payout model.
module tb_change_dispenser;
    localparam int P  = 4;
    localparam int G  = 2;
    localparam int T  = 16;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          change_valid;
    logic [7:0]    change_amount;
    logic          change_ready;
    logic          load_en;
    logic [3:0]    load_coin;
    logic [IW-1:0] load_count;
    logic          coin_sensed;
    logic [3:0]    eject;
    logic          busy;
    logic          done;
    logic          error;
    logic [7:0]    remaining;
    logic [3:0]    inv_empty;

    change_dispenser #(
        .PULSE_CYCLES(P), .GAP_CYCLES(G), .SENSE_TIMEOUT(T), .INV_W(IW)
    ) dut (
        .clk(clk), .reset(reset), .change_valid(change_valid),
        .change_amount(change_amount), .change_ready(change_ready),
        .load_en(load_en), .load_coin(load_coin), .load_count(load_count),
        .coin_sensed(coin_sensed), .eject(eject), .busy(busy), .done(done),
        .error(error), .remaining(remaining), .inv_empty(inv_empty)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         VAL[4] = '{1, 2, 5, 10};
    int         mcnt[4];
    bit [3:0]   jam;
    int         fixed_dly;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int         start_q[$];
    int         end_q[$];
    int         exp_rem;
    bit         exp_err;
    int         cyc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [3:0] model_empty();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (mcnt[i] == 0);
        return e;
    endfunction

    // Greedy payout at coin granularity; jammed tubes are emptied without paying.
    task automatic model_run(input int amt);
        int rem;
        int best;
        bit stuck;
        rem = amt;
        stuck = 0;
        exp_err = 0;
        exp_q.delete();
        while (rem > 0 && !stuck) begin
            best = -1;
            for (int i = 0; i < 4; i++) if (VAL[i] <= rem && mcnt[i] > 0) best = i;
            if (best < 0) begin
                exp_err = 1;
                stuck = 1;
            end else begin
                exp_q.push_back(4'(1 << best));
                if (jam[best]) mcnt[best] = 0;
                else begin
                    rem -= VAL[best];
                    mcnt[best]--;
                end
            end
        end
        exp_rem = rem;
    endtask

    // Exit sensor: fires a delayed pulse for every coin ejected from a working tube.
    initial begin
        int sd, sl;
        logic [3:0] sprev;
        coin_sensed = 1'b0;
        sd = 0; sl = 0; sprev = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                sd = 0; sl = 0; sprev = '0;
                coin_sensed = 1'b0;
            end else begin
                if (eject != 0 && sprev == 0 && !jam[oh_idx(eject)]) begin
                    sd = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, P + T - 1));
                    sl = (fixed_dly >= 0) ? 2 : int'($urandom_range(1, 2));
                end
                if (sd == 0 && sl > 0) begin
                    coin_sensed = 1'b1;
                    sl--;
                end else begin
                    coin_sensed = 1'b0;
                    if (sd > 0) sd--;
                end
                sprev = eject;
            end
        end
    end

    // Eject monitor: logs each pulse and its start/end cycle, checks width and one-hotness.
    initial begin
        logic [3:0] prev;
        int width;
        prev = '0; width = 0; cyc = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!reset) begin
                prev = '0;
                width = 0;
            end else begin
                if (eject != 0) begin
                    if (prev == 0) begin
                        chk("eject_onehot", 32'($onehot(eject)), 32'd1);
                        obs_q.push_back(eject);
                        start_q.push_back(cyc);
                        width = 1;
                    end else begin
                        width++;
                    end
                end else if (prev != 0) begin
                    chk("pulse_width", width, P);
                    end_q.push_back(cyc);
                end
                prev = eject;
            end
        end
    end

    task automatic load_tube(input logic [3:0] mask, input int cnt);
        @(negedge clk);
        load_en = 1'b1;
        load_coin = mask;
        load_count = IW'(cnt);
        @(negedge clk);
        load_en = 1'b0;
        if ($onehot(mask)) mcnt[oh_idx(mask)] = cnt;
    endtask

    task automatic load_all(input int c3, input int c2, input int c1, input int c0);
        load_tube(4'b1000, c3);
        load_tube(4'b0100, c2);
        load_tube(4'b0010, c1);
        load_tube(4'b0001, c0);
    endtask

    task automatic do_payout(input int amt, input bit load_during, output int lat);
        int n;
        model_run(amt);
        obs_q.delete(); start_q.delete(); end_q.delete();
        @(negedge clk);
        chk("ready_idle", change_ready, 1);
        change_valid = 1'b1;
        change_amount = 8'(amt);
        @(posedge clk); #2;
        change_valid = 1'b0;
        if (load_during) begin
            load_en = 1'b1;
            load_coin = 4'b0001;
            load_count = IW'(9);
        end
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        load_en = 1'b0;
        // The controller captures done at the edge after the one where it is seen here.
        lat = n + 1;
        chk("done_seen", done, 1);
        chk("error", error, exp_err);
        chk("remaining", remaining, exp_rem);
        chk("inv_empty", inv_empty, model_empty());
        chk("n_pulses", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk("coin_order", obs_q[i], exp_q[i]);
        @(posedge clk); #2;
        chk("done_onecycle", done, 0);
        chk("busy_after", busy, 0);
        chk("error_held", error, exp_err);
    endtask

    initial begin
        int lat;
        reset = 1'b0;
        change_valid = 1'b0;
        change_amount = '0;
        load_en = 1'b0;
        load_coin = '0;
        load_count = '0;
        jam = '0;
        fixed_dly = 2;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #2;
        chk("rst_ready", change_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_eject", eject, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_inv_empty", inv_empty, 4'b1111);

        // All denominations in stock: 18 pays $1, 50c, 20c, 10c.
        load_all(5, 5, 5, 5);
        do_payout(18, 0, lat);

        // Only 50c usable for 20; spacing is the gap plus the select cycle.
        load_all(0, 5, 0, 0);
        do_payout(20, 0, lat);
        for (int i = 0; i + 1 < start_q.size() && i < end_q.size(); i++)
            chk("gap_len", start_q[i + 1] - end_q[i], G + 1);

        // Silent $1 tube times out and is emptied; the rest comes from 50c.
        load_all(2, 5, 0, 0);
        jam = 4'b1000;
        do_payout(10, 0, lat);
        if (start_q.size() > 1 && end_q.size() > 0)
            chk("timeout_len", start_q[1] - end_q[0], T + 1);
        else
            chk("timeout_pulses", start_q.size(), 3);
        jam = '0;

        // 20c only, request 3: one coin, then shortfall of 1.
        load_all(0, 0, 5, 0);
        do_payout(3, 0, lat);

        // Loads during a payout are ignored, so the 10c shortfall remains.
        load_all(0, 0, 1, 0);
        do_payout(3, 1, lat);
        do_payout(0, 0, lat);
        chk("zero_latency", lat, 2);

        // Multi-bit load select is ignored.
        load_tube(4'b0011, 7);
        @(posedge clk); #2;
        chk("bad_load", inv_empty, model_empty());

        fixed_dly = -1;
        for (int it = 0; it < 40; it++) begin
            for (int t = 0; t < 4; t++) begin
                if ($urandom_range(0, 1) == 1) begin
                    logic [3:0] m;
                    m = 4'(1 << t);
                    if ($urandom_range(0, 5) == 0) m = m | 4'(1 << ((t + 1) % 4));
                    load_tube(m, int'($urandom_range(0, 8)));
                end
            end
            for (int t = 0; t < 4; t++) jam[t] = ($urandom_range(0, 7) == 0);
            do_payout(int'($urandom_range(0, 40)), 0, lat);
        end
        jam = '0;

        // Reset in the second pulse cycle must drop the solenoid at once.
        fixed_dly = 2;
        load_all(5, 5, 5, 5);
        obs_q.delete();
        @(negedge clk);
        change_valid = 1'b1;
        change_amount = 8'd30;
        @(posedge clk); #2;
        change_valid = 1'b0;
        for (int n = 0; n < 50 && eject == 0; n++) begin
            @(posedge clk); #2;
        end
        chk("pulse_started", 32'(eject != 0), 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("rst_eject_now", eject, 0);
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        obs_q.delete();
        @(posedge clk); #2;
        chk("rst2_ready", change_ready, 1);
        chk("rst2_busy", busy, 0);
        chk("rst2_inv_empty", inv_empty, 4'b1111);
        chk("rst2_remaining", remaining, 0);
        repeat (10) @(posedge clk);
        #2;
        chk("rst2_no_resume", obs_q.size(), 0);
        chk("rst2_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
